// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, frame = start, 8 data (LSB first), parity, stop.
// Ports: clk, rst (sync, active-high), rx (async line), os_tick (oversample
// strobe), p_sel (1=even, 0=odd parity) -> data_out, rx_done, parity_err,
// frame_err, busy.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       os_tick,
    input  logic       p_sel,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            rx_m;
    logic            rx_s;
    logic [TW-1:0]   tick_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_mis;

    logic            at_mid;
    logic            at_last;
    logic            exp_par;
    logic            tick_clr;
    logic            shift_en;
    logic            bit_clr;
    logic            par_ld;
    logic            done;

    // Synchronizer presets to the idle level so reset never looks like a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign at_mid  = os_tick && (tick_cnt == MID);
    assign at_last = os_tick && (tick_cnt == LAST);
    assign exp_par = p_sel ? (^shreg) : ~(^shreg);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        tick_clr = 1'b0;
        shift_en = 1'b0;
        bit_clr  = 1'b0;
        par_ld   = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    tick_clr = 1'b1;
                    state_n  = START;
                end
            end
            START: begin
                // Start bit must still be low at its midpoint, else glitch.
                if (at_mid) begin
                    if (!rx_s) begin
                        tick_clr = 1'b1;
                        bit_clr  = 1'b1;
                        state_n  = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (at_last) begin
                    tick_clr = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
            end
            PARITY: begin
                if (at_last) begin
                    tick_clr = 1'b1;
                    par_ld   = 1'b1;
                    state_n  = STOP;
                end
            end
            STOP: begin
                // Leave at the stop midpoint so a back-to-back start is seen.
                if (at_last) begin
                    tick_clr = 1'b1;
                    done     = 1'b1;
                    state_n  = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_mis    <= 1'b0;
            data_out   <= '0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (tick_clr)     tick_cnt <= '0;
            else if (os_tick) tick_cnt <= tick_cnt + TW'(1);
            if (bit_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shreg   <= {rx_s, shreg[7:1]};
            if (par_ld)   par_mis <= rx_s ^ exp_par;
            if (done) begin
                data_out   <= shreg;
                parity_err <= par_mis;
                frame_err  <= ~rx_s;
                rx_done    <= 1'b1;
            end
        end
    end

endmodule
